// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants for the push-button FIFO: default word width and depth,
// plus the derived pointer and occupancy-count widths.
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 8;

  // Pointer width; the count needs one extra bit to represent DEPTH itself.
  localparam int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_WIDTH  = FIFO_ADDR_WIDTH + 1;

endpackage : fifo_pkg

// File: rtl/button_fifo_if.sv
// ---------------------------------------------------------------------------
// button_fifo_if
// Groups the FIFO request and status signals.
//   master : the debouncer/switch side. It drives fifoPush, fifoPop,
//            fifoDataIn and fifoClrErr, and observes the status outputs.
//   slave  : the FIFO. It consumes the requests and drives fifoDataOut,
//            fifoFull, fifoEmpty, fifoCount, fifoOverflow and fifoUnderflow.
// ---------------------------------------------------------------------------
interface button_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
);

  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic                  fifoPush;
  logic                  fifoPop;
  logic [DATA_WIDTH-1:0] fifoDataIn;
  logic                  fifoClrErr;
  logic [DATA_WIDTH-1:0] fifoDataOut;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [CNT_WIDTH-1:0]  fifoCount;
  logic                  fifoOverflow;
  logic                  fifoUnderflow;

  modport master (
    output fifoPush, fifoPop, fifoDataIn, fifoClrErr,
    input  fifoDataOut, fifoFull, fifoEmpty, fifoCount,
           fifoOverflow, fifoUnderflow
  );

  modport slave (
    input  fifoPush, fifoPop, fifoDataIn, fifoClrErr,
    output fifoDataOut, fifoFull, fifoEmpty, fifoCount,
           fifoOverflow, fifoUnderflow
  );

endinterface : button_fifo_if

// File: rtl/button_fifo_edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Turns each 0->1 transition of a level input into a single-cycle pulse.
// The pulse is registered, so it appears one cycle after the rising edge
// is sampled. Both registers reset to 0, so a level that is already high
// when reset releases is seen as a rising edge.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   level_i : level input
//   pulse_o : one-cycle pulse per rising edge of level_i
// ---------------------------------------------------------------------------
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= level_i;
      pulse_q <= level_i & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule : edge_detect

// File: rtl/button_fifo.sv
// ---------------------------------------------------------------------------
// button_fifo
// Synchronous FIFO placed after the push-button debouncers. A push stores
// the switch word, and a pop loads the oldest word into a held output
// register that drives the LEDs. Full, empty, occupancy and sticky
// overflow/underflow flags drive the status display. All outputs are
// registered.
//
// Ports:
//   fifoClk : clock, rising edge
//   fifoRst : asynchronous active-low reset
//   bus     : button_fifo_if.slave. Carries the push/pop/clear requests,
//             the data in, and every status and data output.
//
// Build option FIFO_EDGE_DETECT_EN: when defined, fifoPush and fifoPop are
// treated as levels. Each rising edge yields one request, one cycle later.
// When undefined, they are used directly as per-cycle strobes.
// ---------------------------------------------------------------------------
module button_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic          fifoClk,
  input  logic          fifoRst,
  button_fifo_if.slave  bus
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_FULL  = CNT_WIDTH'(DEPTH);

  // Request strobes, either taken straight from the bus or edge-detected.
  logic push_s;
  logic pop_s;

`ifdef FIFO_EDGE_DETECT_EN
  edge_detect u_push_edge (
    .clk     (fifoClk),
    .rst_n   (fifoRst),
    .level_i (bus.fifoPush),
    .pulse_o (push_s)
  );

  edge_detect u_pop_edge (
    .clk     (fifoClk),
    .rst_n   (fifoRst),
    .level_i (bus.fifoPop),
    .pulse_o (pop_s)
  );
`else
  assign push_s = bus.fifoPush;
  assign pop_s  = bus.fifoPop;
`endif

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q,    count_d;
  logic                  full_q,     full_d;
  logic                  empty_q,    empty_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  ovf_q,      ovf_d;
  logic                  udf_q,      udf_d;

  logic push_ok;
  logic pop_ok;

  // A push into a full FIFO is still accepted when a pop frees the head
  // slot on the same edge.
  assign push_ok = push_s & (~full_q | pop_s);
  assign pop_ok  = pop_s & ~empty_q;

  // NOTE: every signal gets a default at the top of always_comb, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q];
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Flags are decoded from the next count so that they stay registered
    // and in step with fifoCount.
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);

    // Sticky error flags: when a set and a clear arrive together, the set wins.
    if (push_s && !push_ok)  ovf_d = 1'b1;
    else if (bus.fifoClrErr) ovf_d = 1'b0;

    if (pop_s && !pop_ok)    udf_d = 1'b1;
    else if (bus.fifoClrErr) udf_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only. A pop and
  // a push on the same full-FIFO edge then read the old head and write
  // the freed slot without racing each other.
  always_ff @(posedge fifoClk or negedge fifoRst) begin
    if (!fifoRst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      data_out_q <= data_out_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // NOTE: the storage array has no reset. The pointers and count define
  // which entries are valid, so stale contents are never observed, and
  // leaving the array unreset lets it map onto plain flops or LUT RAM.
  always_ff @(posedge fifoClk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.fifoDataIn;
  end

  assign bus.fifoDataOut   = data_out_q;
  assign bus.fifoFull      = full_q;
  assign bus.fifoEmpty     = empty_q;
  assign bus.fifoCount     = count_q;
  assign bus.fifoOverflow  = ovf_q;
  assign bus.fifoUnderflow = udf_q;

endmodule : button_fifo

// File: tb/tb_button_fifo.sv
// ---------------------------------------------------------------------------
// tb_button_fifo
// Self-checking bench for button_fifo. A queue-based reference model
// tracks the expected outputs, and a negedge process compares the DUT
// against it on every cycle. Directed sequences add literal expectations
// that pin the model itself, and a randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_button_fifo;
  import fifo_pkg::*;

  localparam int DW  = FIFO_DATA_WIDTH;
  localparam int DEP = FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  button_fifo_if bus ();

  button_fifo dut (
    .fifoClk (clk),
    .fifoRst (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_udf;
`ifdef FIFO_EDGE_DETECT_EN
  logic e_prev_push, e_prev_pop, e_pend_push, e_pend_pop;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
`ifdef FIFO_EDGE_DETECT_EN
      e_prev_push = 1'b0; e_prev_pop = 1'b0;
      e_pend_push = 1'b0; e_pend_pop = 1'b0;
`endif
    end else begin
      logic p, q, p_acc, q_acc;
`ifdef FIFO_EDGE_DETECT_EN
      p = e_pend_push;
      q = e_pend_pop;
      e_pend_push = bus.fifoPush && !e_prev_push;
      e_pend_pop  = bus.fifoPop  && !e_prev_pop;
      e_prev_push = bus.fifoPush;
      e_prev_pop  = bus.fifoPop;
`else
      p = bus.fifoPush;
      q = bus.fifoPop;
`endif
      q_acc = q && (m_q.size() != 0);
      p_acc = p && ((m_q.size() < DEP) || q);
      if (q_acc) m_dout = m_q.pop_front();
      if (p_acc) m_q.push_back(bus.fifoDataIn);
      if (p && !p_acc)          m_ovf = 1'b1;
      else if (bus.fifoClrErr)  m_ovf = 1'b0;
      if (q && !q_acc)          m_udf = 1'b1;
      else if (bus.fifoClrErr)  m_udf = 1'b0;
    end
  end

  // Compare process: outputs are stable half a cycle after the edge.
  always @(negedge clk) begin
    check("m.dout",  32'(bus.fifoDataOut),   32'(m_dout));
    check("m.count", 32'(bus.fifoCount),     32'(m_q.size()));
    check("m.full",  32'(bus.fifoFull),      32'(m_q.size() == DEP));
    check("m.empty", 32'(bus.fifoEmpty),     32'(m_q.size() == 0));
    check("m.ovf",   32'(bus.fifoOverflow),  32'(m_ovf));
    check("m.udf",   32'(bus.fifoUnderflow), 32'(m_udf));
  end

  // ---------------- stimulus helpers ----------------
  // Presents one set of requests to the next edge, then returns 1 ns after it.
  task automatic step(input logic p, input logic q, input logic [DW-1:0] d, input logic c);
    bus.fifoPush   = p;
    bus.fifoPop    = q;
    bus.fifoDataIn = d;
    bus.fifoClrErr = c;
    @(posedge clk);
    #1;
    bus.fifoPush   = 1'b0;
    bus.fifoPop    = 1'b0;
    bus.fifoClrErr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.count", 32'(bus.fifoCount), 32'd0);
    check("rst.empty", 32'(bus.fifoEmpty), 32'd1);
    check("rst.full",  32'(bus.fifoFull),  32'd0);
    check("rst.dout",  32'(bus.fifoDataOut), 32'd0);
    check("rst.ovf",   32'(bus.fifoOverflow), 32'd0);
    check("rst.udf",   32'(bus.fifoUnderflow), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.fifoPush   = 1'b0;
    bus.fifoPop    = 1'b0;
    bus.fifoDataIn = '0;
    bus.fifoClrErr = 1'b0;
    do_reset();

`ifndef FIFO_EDGE_DETECT_EN
    // In-order push/pop of three words.
    step(1, 0, 8'h11, 0);
    step(1, 0, 8'h22, 0);
    step(1, 0, 8'h33, 0);
    check("t1.count3", 32'(bus.fifoCount), 32'd3);
    step(0, 1, 8'h00, 0); check("t1.pop0", 32'(bus.fifoDataOut), 32'h11);
    step(0, 1, 8'h00, 0); check("t1.pop1", 32'(bus.fifoDataOut), 32'h22);
    step(0, 1, 8'h00, 0); check("t1.pop2", 32'(bus.fifoDataOut), 32'h33);
    check("t1.count0", 32'(bus.fifoCount), 32'd0);
    check("t1.empty",  32'(bus.fifoEmpty), 32'd1);

    // Fill, overflow, then drain.
    for (int i = 0; i < DEP; i++) step(1, 0, 8'(8'hA0 + i), 0);
    check("t2.full", 32'(bus.fifoFull), 32'd1);
    step(1, 0, 8'hFF, 0);
    check("t2.count8", 32'(bus.fifoCount), 32'd8);
    check("t2.ovf",    32'(bus.fifoOverflow), 32'd1);
    for (int i = 0; i < DEP; i++) begin
      step(0, 1, 8'h00, 0);
      check("t2.drain", 32'(bus.fifoDataOut), 32'(8'hA0 + i));
    end
    check("t2.empty", 32'(bus.fifoEmpty), 32'd1);
    step(0, 0, 8'h00, 1);
    check("t2.clr", 32'(bus.fifoOverflow), 32'd0);

    // Underflow, clear, and set-wins-over-clear.
    do_reset();
    step(0, 1, 8'h00, 0);
    check("t3.udf",  32'(bus.fifoUnderflow), 32'd1);
    check("t3.dout", 32'(bus.fifoDataOut),   32'd0);
    step(0, 0, 8'h00, 1);
    check("t3.clr",  32'(bus.fifoUnderflow), 32'd0);
    step(0, 1, 8'h00, 1);
    check("t3.setwins", 32'(bus.fifoUnderflow), 32'd1);
    step(0, 0, 8'h00, 1);

    // Simultaneous push and pop while full.
    for (int i = 0; i < DEP; i++) step(1, 0, 8'(8'h80 + i), 0);
    step(1, 1, 8'h5A, 0);
    check("t4.head",  32'(bus.fifoDataOut),  32'h80);
    check("t4.count", 32'(bus.fifoCount),    32'd8);
    check("t4.noovf", 32'(bus.fifoOverflow), 32'd0);
    for (int i = 0; i < DEP; i++) step(0, 1, 8'h00, 0);
    check("t4.last",  32'(bus.fifoDataOut),  32'h5A);
    check("t4.empty", 32'(bus.fifoEmpty),    32'd1);

    // Traffic across a pointer wrap, then an asynchronous reset mid-cycle.
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 0);
    step(1, 0, 8'hC3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5.count", 32'(bus.fifoCount),   32'd0);
    check("t5.empty", 32'(bus.fifoEmpty),   32'd1);
    check("t5.dout",  32'(bus.fifoDataOut), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 8'h77, 0);
    step(0, 1, 8'h00, 0);
    check("t5.after", 32'(bus.fifoDataOut), 32'h77);
`else
    // A level held high yields exactly one request, one cycle late.
    bus.fifoDataIn = 8'h3C;
    bus.fifoPush   = 1'b1;
    @(posedge clk); #1;
    check("e.count_rise", 32'(bus.fifoCount), 32'd0);
    @(posedge clk); #1;
    check("e.count_1", 32'(bus.fifoCount), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("e.count_held", 32'(bus.fifoCount), 32'd1);
    bus.fifoPush = 1'b0;
    step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    check("e.dout", 32'(bus.fifoDataOut), 32'h3C);
`endif

    // Randomized phases: push-heavy, balanced, then pop-heavy.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic p, q;
        p = ($urandom_range(0, 3) < 3 - ph);
        q = ($urandom_range(0, 3) < 1 + ph);
        step(p, q, 8'($urandom), ($urandom_range(0, 7) == 0));
      end
    end

    step(0, 0, 8'h00, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_button_fifo
